// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller: per-register stall/flush and PC hold/select for the 5-stage core.
// Latency: stall/flush/pc outputs are combinational from state + inputs; bus_timeout is registered (1 cycle).
// Backpressure: imem/dmem busy hold or bubble the pipeline; flush always wins over stall for a register.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   id_rs1/id_rs2, id_use_*  source registers of the ID instruction and whether they are read
//   ex_waddr, ex_mem_read    destination and load flag of the EX instruction
//   ex_branch_taken          EX resolved a taken branch/jump
//   mem_exception, mem_xret  MEM-stage trap / xRET request
//   imem_busy, dmem_busy     fetch / data access still outstanding
//   pc_stall, pc_sel         PC hold and source select (00 seq, 01 branch, 10 trap vector, 11 xepc)
//   *_stall, *_flush         per pipeline register hold / bubble insert
//   fsm_state                debug view of the controller state (00 RUN, 01 DISCARD, 10 TRAP)
//   bus_timeout              one-cycle pulse after MAX_WAIT consecutive busy cycles
module pipeline_ctrl #(
  parameter int TRAP_CYCLES = 2,
  parameter int MAX_WAIT    = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_waddr,
  input  logic       ex_mem_read,
  input  logic       ex_branch_taken,
  input  logic       mem_exception,
  input  logic       mem_xret,
  input  logic       imem_busy,
  input  logic       dmem_busy,
  output logic       pc_stall,
  output logic [1:0] pc_sel,
  output logic       ifid_stall,
  output logic       ifid_flush,
  output logic       idex_stall,
  output logic       idex_flush,
  output logic       exmem_stall,
  output logic       exmem_flush,
  output logic       memwb_stall,
  output logic       memwb_flush,
  output logic [1:0] fsm_state,
  output logic       bus_timeout
);

  localparam logic [1:0] ST_RUN     = 2'b00;
  localparam logic [1:0] ST_DISCARD = 2'b01;
  localparam logic [1:0] ST_TRAP    = 2'b10;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_TRAP   = 2'b10;
  localparam logic [1:0] PC_XEPC   = 2'b11;

  localparam int TW = (TRAP_CYCLES > 1) ? $clog2(TRAP_CYCLES) : 1;
  localparam int WW = $clog2(MAX_WAIT);
  localparam logic [TW-1:0] TRAP_INIT = TW'(TRAP_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  logic [1:0]    state, state_nxt;
  logic [TW-1:0] trap_cnt, trap_cnt_nxt;
  logic [WW-1:0] wait_cnt;

  logic          load_use;
  logic          trap_req;

  logic          pcs_c, ifs_c, iff_c, ids_c, idf_c, exs_c, exf_c, mwf_c;
  logic [1:0]    sel_c;

  // x0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign load_use = ex_mem_read && (ex_waddr != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_waddr)) ||
                     (id_use_rs2 && (id_rs2 == ex_waddr)));

  assign trap_req = mem_exception || mem_xret;

  always_comb begin
    pcs_c = 1'b0;
    ifs_c = 1'b0;
    iff_c = 1'b0;
    ids_c = 1'b0;
    idf_c = 1'b0;
    exs_c = 1'b0;
    exf_c = 1'b0;
    mwf_c = 1'b0;
    sel_c = PC_SEQ;
    trap_cnt_nxt = trap_cnt;
    // The unused encoding falls back to RUN.
    state_nxt = ((state == ST_DISCARD) || (state == ST_TRAP)) ? state : ST_RUN;

    if (state == ST_TRAP) begin
      // CSR update window: front end held and emptied; MEM only holds a bubble,
      // so a fresh mem_exception here is not a real instruction and is ignored.
      pcs_c = 1'b1;
      iff_c = 1'b1;
      idf_c = 1'b1;
      exf_c = 1'b1;
      if (trap_cnt == '0) begin
        state_nxt = ST_RUN;
      end else begin
        trap_cnt_nxt = trap_cnt - 1'b1;
      end
    end else if (trap_req) begin
      // Trap entry beats every other hazard, including an outstanding dmem access.
      iff_c = 1'b1;
      idf_c = 1'b1;
      exf_c = 1'b1;
      mwf_c = 1'b1;
      sel_c = mem_exception ? PC_TRAP : PC_XEPC;
      state_nxt    = ST_TRAP;
      trap_cnt_nxt = TRAP_INIT;
    end else if (state == ST_DISCARD) begin
      // PC already points at the branch target; drop the stale fetch including
      // the cycle its data finally returns.
      pcs_c = 1'b1;
      iff_c = 1'b1;
      if (dmem_busy) begin
        ids_c = 1'b1;
        exs_c = 1'b1;
        mwf_c = 1'b1;
      end
      if (!imem_busy) begin
        state_nxt = ST_RUN;
      end
    end else if (dmem_busy) begin
      // Freeze everything up to MEM; a taken branch in EX is re-presented later.
      pcs_c = 1'b1;
      ifs_c = 1'b1;
      ids_c = 1'b1;
      exs_c = 1'b1;
      mwf_c = 1'b1;
    end else if (ex_branch_taken) begin
      iff_c = 1'b1;
      idf_c = 1'b1;
      sel_c = PC_BRANCH;
      if (imem_busy) begin
        state_nxt = ST_DISCARD;
      end
    end else if (load_use) begin
      // One bubble into EX; forwarding from MEM covers the remaining distance.
      pcs_c = 1'b1;
      ifs_c = 1'b1;
      idf_c = 1'b1;
    end else if (imem_busy) begin
      pcs_c = 1'b1;
      iff_c = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RUN;
      trap_cnt <= '0;
    end else begin
      state    <= state_nxt;
      trap_cnt <= trap_cnt_nxt;
    end
  end

  // Consecutive-busy watchdog; restarts from zero after each pulse so a stuck
  // bus produces a periodic timeout rather than a wrapped count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      bus_timeout <= 1'b0;
    end else begin
      bus_timeout <= 1'b0;
      if (imem_busy || dmem_busy) begin
        if (wait_cnt == WAIT_LAST) begin
          wait_cnt    <= '0;
          bus_timeout <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // Outputs are forced quiet while reset is held so the pipeline registers
  // never see a stall or flush from undefined inputs.
  assign pc_stall    = pcs_c & ~rst;
  assign pc_sel      = rst ? PC_SEQ : sel_c;
  assign ifid_stall  = ifs_c & ~rst;
  assign ifid_flush  = iff_c & ~rst;
  assign idex_stall  = ids_c & ~rst;
  assign idex_flush  = idf_c & ~rst;
  assign exmem_stall = exs_c & ~rst;
  assign exmem_flush = exf_c & ~rst;
  // MEM/WB is never held: while MEM waits it emits bubbles into WB instead.
  assign memwb_stall = 1'b0;
  assign memwb_flush = mwf_c & ~rst;
  assign fsm_state   = state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  localparam int TRAP_CYCLES = 2;
  localparam int MAX_WAIT    = 8;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic [4:0] waddr;
    logic       mrd;
    logic       br;
    logic       exc;
    logic       xret;
    logic       ib;
    logic       db;
  } in_t;

  typedef struct packed {
    logic       pc_stall;
    logic [1:0] pc_sel;
    logic       ifid_s;
    logic       ifid_f;
    logic       idex_s;
    logic       idex_f;
    logic       exmem_s;
    logic       exmem_f;
    logic       memwb_s;
    logic       memwb_f;
    logic [1:0] st;
    logic       to;
  } out_t;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_waddr;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
  logic       mem_exception, mem_xret, imem_busy, dmem_busy;
  logic       pc_stall;
  logic [1:0] pc_sel;
  logic       ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic       exmem_stall, exmem_flush, memwb_stall, memwb_flush;
  logic [1:0] fsm_state;
  logic       bus_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0 run, 1 discarding stale fetch, 2 trap window.
  int   m_mode;
  int   m_trap_left;
  int   m_run;
  bit   m_to;
  out_t m_exp;

  pipeline_ctrl #(.TRAP_CYCLES(TRAP_CYCLES), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_waddr(ex_waddr), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_exception(mem_exception), .mem_xret(mem_xret),
    .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .pc_stall(pc_stall), .pc_sel(pc_sel),
    .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_flush(idex_flush),
    .exmem_stall(exmem_stall), .exmem_flush(exmem_flush),
    .memwb_stall(memwb_stall), .memwb_flush(memwb_flush),
    .fsm_state(fsm_state), .bus_timeout(bus_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  function automatic out_t mk(input int ps, input int sel, input int fs, input int ff,
                              input int ds, input int df, input int es, input int ef,
                              input int wf, input int st, input int to);
    out_t o;
    o = '0;
    o.pc_stall = 1'(ps);
    o.pc_sel   = 2'(sel);
    o.ifid_s   = 1'(fs);
    o.ifid_f   = 1'(ff);
    o.idex_s   = 1'(ds);
    o.idex_f   = 1'(df);
    o.exmem_s  = 1'(es);
    o.exmem_f  = 1'(ef);
    o.memwb_f  = 1'(wf);
    o.st       = 2'(st);
    o.to       = 1'(to);
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o = {pc_stall, pc_sel, ifid_stall, ifid_flush, idex_stall, idex_flush,
         exmem_stall, exmem_flush, memwb_stall, memwb_flush, fsm_state, bus_timeout};
    return o;
  endfunction

  task automatic drive(input in_t i);
    id_rs1 = i.rs1; id_rs2 = i.rs2; id_use_rs1 = i.use1; id_use_rs2 = i.use2;
    ex_waddr = i.waddr; ex_mem_read = i.mrd; ex_branch_taken = i.br;
    mem_exception = i.exc; mem_xret = i.xret; imem_busy = i.ib; dmem_busy = i.db;
  endtask

  task automatic model_reset();
    m_mode = 0; m_trap_left = 0; m_run = 0; m_to = 1'b0;
  endtask

  // Expected control outputs from the hazard priority rules.
  function automatic out_t predict(input in_t i);
    out_t o;
    bit   hazard_lu;
    o = '0;
    o.st = 2'(m_mode);
    o.to = m_to;
    hazard_lu = i.mrd && (i.waddr != 0) &&
                ((i.use1 && i.rs1 == i.waddr) || (i.use2 && i.rs2 == i.waddr));
    if (m_mode == 2) begin
      o.pc_stall = 1; o.ifid_f = 1; o.idex_f = 1; o.exmem_f = 1;
    end else if (i.exc || i.xret) begin
      o.ifid_f = 1; o.idex_f = 1; o.exmem_f = 1; o.memwb_f = 1;
      o.pc_sel = i.exc ? 2'd2 : 2'd3;
    end else if (m_mode == 1) begin
      o.pc_stall = 1; o.ifid_f = 1;
      if (i.db) begin o.idex_s = 1; o.exmem_s = 1; o.memwb_f = 1; end
    end else if (i.db) begin
      o.pc_stall = 1; o.ifid_s = 1; o.idex_s = 1; o.exmem_s = 1; o.memwb_f = 1;
    end else if (i.br) begin
      o.ifid_f = 1; o.idex_f = 1; o.pc_sel = 2'd1;
    end else if (hazard_lu) begin
      o.pc_stall = 1; o.ifid_s = 1; o.idex_f = 1;
    end else if (i.ib) begin
      o.pc_stall = 1; o.ifid_f = 1;
    end
    return o;
  endfunction

  task automatic commit(input in_t i);
    if (i.ib || i.db) begin
      m_run++;
      m_to = ((m_run % MAX_WAIT) == 0);
    end else begin
      m_run = 0;
      m_to  = 1'b0;
    end
    if (m_mode == 2) begin
      m_trap_left--;
      if (m_trap_left == 0) m_mode = 0;
    end else if (i.exc || i.xret) begin
      m_mode = 2;
      m_trap_left = TRAP_CYCLES;
    end else if (m_mode == 1) begin
      if (!i.ib) m_mode = 0;
    end else if (!i.db && i.br && i.ib) begin
      m_mode = 1;
    end
  endtask

  // One clock: apply inputs mid-cycle, sample outputs, then advance the model on the edge.
  task automatic cycle(input in_t i, output out_t act);
    @(negedge clk);
    drive(i);
    #1;
    m_exp = predict(i);
    act = sample();
    @(posedge clk);
    commit(i);
  endtask

  task automatic test_reset();
    in_t  t;
    out_t act;
    t = '0; t.exc = 1; t.br = 1; t.db = 1; t.ib = 1; t.mrd = 1; t.waddr = 3; t.rs1 = 3; t.use1 = 1;
    drive(t);
    #3;
    act = sample();
    n_tests++;
    if (act !== '0) begin
      n_fail++;
      $display("FAIL reset_held: got %h expected %h", act, out_t'('0));
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive('0);
    #1;
    act = sample();
    n_tests++;
    if (act !== '0) begin
      n_fail++;
      $display("FAIL reset_release: got %h expected %h", act, out_t'('0));
    end
    @(posedge clk);
    commit('0);
  endtask

  task automatic test_load_use();
    in_t  s[5];
    out_t e[5];
    in_t  t;
    out_t act;
    t = '0; t.mrd = 1; t.waddr = 5; t.rs1 = 5; t.use1 = 1;
    s[0] = t; e[0] = mk(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    s[1] = '0; e[1] = '0;
    t.waddr = 0; t.rs1 = 0;
    s[2] = t; e[2] = '0;
    t = '0; t.mrd = 1; t.waddr = 7; t.rs1 = 3; t.use1 = 1; t.rs2 = 7; t.use2 = 1;
    s[3] = t; e[3] = mk(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    t.use2 = 0;
    s[4] = t; e[4] = '0;
    for (int k = 0; k < 5; k++) begin
      cycle(s[k], act);
      n_tests++;
      if (act !== e[k]) begin
        n_fail++;
        $display("FAIL load_use step %0d: got %h expected %h", k, act, e[k]);
      end
    end
  endtask

  task automatic test_branch_discard();
    in_t  s[10];
    out_t e[10];
    out_t act;
    for (int k = 0; k < 10; k++) s[k] = '0;
    s[0].br = 1; s[0].ib = 1; e[0] = mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    s[1].ib = 1;              e[1] = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    s[2].ib = 1;              e[2] = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
                              e[3] = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
                              e[4] = '0;
    s[5].br = 1; s[5].ib = 1; e[5] = mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    s[6].ib = 1; s[6].exc = 1; e[6] = mk(0, 2, 0, 1, 0, 1, 0, 1, 1, 1, 0);
                              e[7] = mk(1, 0, 0, 1, 0, 1, 0, 1, 0, 2, 0);
                              e[8] = mk(1, 0, 0, 1, 0, 1, 0, 1, 0, 2, 0);
                              e[9] = '0;
    for (int k = 0; k < 10; k++) begin
      cycle(s[k], act);
      n_tests++;
      if (act !== e[k]) begin
        n_fail++;
        $display("FAIL branch_discard step %0d: got %h expected %h", k, act, e[k]);
      end
    end
  endtask

  task automatic test_trap();
    in_t  s[11];
    out_t e[11];
    out_t act;
    for (int k = 0; k < 11; k++) s[k] = '0;
    s[0].exc = 1; s[0].br = 1; s[0].db = 1; e[0] = mk(0, 2, 0, 1, 0, 1, 0, 1, 1, 0, 0);
                                            e[1] = mk(1, 0, 0, 1, 0, 1, 0, 1, 0, 2, 0);
    s[2].exc = 1;                           e[2] = mk(1, 0, 0, 1, 0, 1, 0, 1, 0, 2, 0);
                                            e[3] = '0;
    s[4].xret = 1;                          e[4] = mk(0, 3, 0, 1, 0, 1, 0, 1, 1, 0, 0);
                                            e[5] = mk(1, 0, 0, 1, 0, 1, 0, 1, 0, 2, 0);
                                            e[6] = mk(1, 0, 0, 1, 0, 1, 0, 1, 0, 2, 0);
    s[7].exc = 1; s[7].xret = 1;            e[7] = mk(0, 2, 0, 1, 0, 1, 0, 1, 1, 0, 0);
                                            e[8] = mk(1, 0, 0, 1, 0, 1, 0, 1, 0, 2, 0);
                                            e[9] = mk(1, 0, 0, 1, 0, 1, 0, 1, 0, 2, 0);
                                            e[10] = '0;
    for (int k = 0; k < 11; k++) begin
      cycle(s[k], act);
      n_tests++;
      if (act !== e[k]) begin
        n_fail++;
        $display("FAIL trap step %0d: got %h expected %h", k, act, e[k]);
      end
    end
  endtask

  task automatic test_dmem_wait();
    in_t  t;
    out_t e;
    out_t act;
    for (int k = 0; k < 6; k++) begin
      t = '0;
      if (k < 5) t.br = 1;
      if (k < 4) t.db = 1;
      if (k < 4)       e = mk(1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0);
      else if (k == 4) e = mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
      else             e = '0;
      cycle(t, act);
      n_tests++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL dmem_wait step %0d: got %h expected %h", k, act, e);
      end
    end
  endtask

  task automatic test_timeout();
    in_t  t;
    out_t e;
    out_t act;
    int   pulses;
    pulses = 0;
    for (int k = 1; k <= 18; k++) begin
      t = '0;
      t.ib = (k <= 17);
      if (k <= 17) e = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, (k == 9 || k == 17) ? 1 : 0);
      else         e = '0;
      cycle(t, act);
      if (act.to) pulses++;
      n_tests++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL timeout cycle %0d: got %h expected %h", k, act, e);
      end
    end
    n_tests++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL timeout_pulse_count: got %0d expected 2", pulses);
    end
  endtask

  // Enter TRAP or DISCARD, then hit reset mid-state with the bus still busy.
  task automatic test_reset_mid(input bit to_discard);
    in_t  t;
    out_t act;
    t = '0;
    if (to_discard) begin
      t.br = 1; t.ib = 1;
    end else begin
      t.exc = 1;
    end
    cycle(t, act);
    n_tests++;
    if (act.st !== 2'b00 || act.pc_sel !== (to_discard ? 2'b01 : 2'b10)) begin
      n_fail++;
      $display("FAIL reset_mid_entry %0d: got %h", to_discard, act);
    end
    @(negedge clk);
    t = '0; t.ib = 1; t.exc = 1; t.br = 1;
    drive(t);
    n_tests++;
    if (fsm_state !== (to_discard ? 2'b01 : 2'b10)) begin
      n_fail++;
      $display("FAIL reset_mid_state %0d: got %b", to_discard, fsm_state);
    end
    rst = 1'b1;
    model_reset();
    #1;
    act = sample();
    n_tests++;
    if (act !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_immediate %0d: got %h expected %h", to_discard, act, out_t'('0));
    end
    repeat (MAX_WAIT + 2) @(posedge clk);
    @(negedge clk);
    #1;
    act = sample();
    n_tests++;
    if (act !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_hold %0d: got %h expected %h", to_discard, act, out_t'('0));
    end
    rst = 1'b0;
    drive('0);
    #1;
    act = sample();
    n_tests++;
    if (act !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_release %0d: got %h expected %h", to_discard, act, out_t'('0));
    end
    @(posedge clk);
    commit('0);
  endtask

  task automatic test_random();
    in_t  t;
    out_t act;
    int   ib_pct;
    int   db_pct;
    int   bad;
    bad = 0;
    for (int k = 0; k < 3000; k++) begin
      if (k % 250 == 0) begin
        ib_pct = $urandom_range(10, 97);
        db_pct = $urandom_range(5, 60);
      end
      t = '0;
      t.rs1   = 5'($urandom_range(0, 3));
      t.rs2   = 5'($urandom_range(0, 3));
      t.waddr = 5'($urandom_range(0, 3));
      t.use1  = ($urandom_range(0, 1) == 1);
      t.use2  = ($urandom_range(0, 1) == 1);
      t.mrd   = ($urandom_range(0, 2) == 0);
      t.br    = ($urandom_range(0, 3) == 0);
      t.exc   = ($urandom_range(0, 24) == 0);
      t.xret  = ($urandom_range(0, 24) == 0);
      t.ib    = ($urandom_range(1, 100) <= ib_pct);
      t.db    = ($urandom_range(1, 100) <= db_pct);
      cycle(t, act);
      n_tests++;
      if (act !== m_exp) begin
        n_fail++;
        bad++;
        if (bad <= 10)
          $display("FAIL random cycle %0d in=%h: got %h expected %h", k, t, act, m_exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive('0);
    model_reset();
    test_reset();
    test_load_use();
    test_branch_discard();
    test_trap();
    test_dmem_wait();
    test_timeout();
    test_reset_mid(1'b0);
    test_reset_mid(1'b1);
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
